// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with clear, load, saturate/wrap policy.
// Ports: div_clock, reset(async high), enable, up_down, clear, load, load_value -> count, at_max, at_zero, wrapped.
module bcd_updown_counter #(
  parameter int NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] MAX_BCD = 16'h1903,
  parameter bit WRAP = 1'b0
) (
  input  logic                    div_clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    at_max,
  output logic                    at_zero,
  output logic                    wrapped
);

  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] count_next;
  logic [W-1:0] count_inc;
  logic [W-1:0] count_dec;
  logic [W-1:0] load_clamp;
  logic [W-1:0] load_sat;
  logic         wrap_next;

  assign at_max  = (count == MAX_BCD);
  assign at_zero = (count == '0);

  // Carry into digit i is set when every lower digit is 9.
  always_comb begin
    logic c;
    logic [3:0] d;
    count_inc = '0;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d = d + 4'd1;
          c = 1'b0;
        end
      end
      count_inc[4*i +: 4] = d;
    end
  end

  // Borrow into digit i is set when every lower digit is 0.
  always_comb begin
    logic b;
    logic [3:0] d;
    count_dec = '0;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d = d - 4'd1;
          b = 1'b0;
        end
      end
      count_dec[4*i +: 4] = d;
    end
  end

  // With every nibble in 0-9, binary order of the packed
  // word equals decimal order, so a plain compare works.
  always_comb begin
    load_clamp = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9)
        load_clamp[4*i +: 4] = 4'd9;
      else
        load_clamp[4*i +: 4] = load_value[4*i +: 4];
    end
    load_sat = (load_clamp > MAX_BCD) ? MAX_BCD : load_clamp;
  end

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    priority case (1'b1)
      clear: count_next = '0;
      load:  count_next = load_sat;
      enable && up_down: begin
        if (at_max) begin
          if (WRAP) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_inc;
        end
      end
      enable: begin
        if (at_zero) begin
          if (WRAP) begin
            count_next = MAX_BCD;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else begin
      count   <= count_next;
      wrapped <= wrap_next;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomized bench for bcd_updown_counter: saturating and wrapping instances
// driven in parallel and compared against a decimal reference model.
module tb_bcd_updown_counter;

  localparam logic [15:0] MAXB = 16'h1903;
  localparam int MAXD = 1903;

  logic        div_clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        up_down;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] count0, count1;
  logic        at_max0, at_max1;
  logic        at_zero0, at_zero1;
  logic        wrapped0, wrapped1;

  int vecs = 0;
  int errs = 0;
  int m[2];
  bit w[2];

  always #5 div_clock = ~div_clock;

  bcd_updown_counter #(
    .NUM_DIGITS(4), .MAX_BCD(MAXB), .WRAP(1'b0)
  ) u_sat (
    .div_clock(div_clock), .reset(reset),
    .enable(enable), .up_down(up_down),
    .clear(clear), .load(load),
    .load_value(load_value), .count(count0),
    .at_max(at_max0), .at_zero(at_zero0),
    .wrapped(wrapped0)
  );

  bcd_updown_counter #(
    .NUM_DIGITS(4), .MAX_BCD(MAXB), .WRAP(1'b1)
  ) u_wrap (
    .div_clock(div_clock), .reset(reset),
    .enable(enable), .up_down(up_down),
    .clear(clear), .load(load),
    .load_value(load_value), .count(count1),
    .at_max(at_max1), .at_zero(at_zero1),
    .wrapped(wrapped1)
  );

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_val(logic [15:0] v);
    int r = 0;
    int d;
    for (int i = 3; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int next_val(int v, bit wrp, bit en, bit ud,
                                  bit clr, bit ld, logic [15:0] lv,
                                  output bit wo);
    int lvd;
    wo = 1'b0;
    if (clr) return 0;
    if (ld) begin
      lvd = bcd_val(lv);
      return (lvd > MAXD) ? MAXD : lvd;
    end
    if (!en) return v;
    if (ud) begin
      if (v == MAXD) begin
        if (wrp) begin wo = 1'b1; return 0; end
        return v;
      end
      return v + 1;
    end
    if (v == 0) begin
      if (wrp) begin wo = 1'b1; return MAXD; end
      return 0;
    end
    return v - 1;
  endfunction

  task automatic check_all(string tag);
    check({tag, ".c0"}, count0, to_bcd(m[0]));
    check({tag, ".mx0"}, 16'(at_max0), 16'(m[0] == MAXD));
    check({tag, ".z0"}, 16'(at_zero0), 16'(m[0] == 0));
    check({tag, ".w0"}, 16'(wrapped0), 16'(w[0]));
    check({tag, ".c1"}, count1, to_bcd(m[1]));
    check({tag, ".mx1"}, 16'(at_max1), 16'(m[1] == MAXD));
    check({tag, ".z1"}, 16'(at_zero1), 16'(m[1] == 0));
    check({tag, ".w1"}, 16'(wrapped1), 16'(w[1]));
  endtask

  task automatic step(string tag, bit en, bit ud, bit clr,
                      bit ld, logic [15:0] lv);
    enable = en;
    up_down = ud;
    clear = clr;
    load = ld;
    load_value = lv;
    @(posedge div_clock);
    m[0] = next_val(m[0], 1'b0, en, ud, clr, ld, lv, w[0]);
    m[1] = next_val(m[1], 1'b1, en, ud, clr, ld, lv, w[1]);
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en, ud, clr, ld;
    logic [15:0] lv;
    int r;
    reset = 1'b1;
    enable = 1'b0;
    up_down = 1'b0;
    clear = 1'b0;
    load = 1'b0;
    load_value = '0;
    m[0] = 0; m[1] = 0;
    w[0] = 0; w[1] = 0;
    #2;
    check("rst.count", count0, 16'h0000);
    check("rst.zero", 16'(at_zero0), 16'd1);
    check("rst.max", 16'(at_max0), 16'd0);
    check("rst.wrap", 16'(wrapped1), 16'd0);
    @(negedge div_clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) step("up10", 1, 1, 0, 0, '0);
    check("up10.final", count0, 16'h0010);

    step("ld999", 0, 0, 0, 1, 16'h0999);
    step("ripple", 1, 1, 0, 0, '0);
    check("ripple.k", count0, 16'h1000);
    step("borrow", 1, 0, 0, 0, '0);
    check("borrow.k", count0, 16'h0999);

    step("ld1902", 0, 0, 0, 1, 16'h1902);
    for (int i = 0; i < 3; i++) step("sat", 1, 1, 0, 0, '0);
    check("sat.k", count0, 16'h1903);
    check("wrap.k", count1, 16'h0001);

    step("clr", 0, 0, 1, 0, '0);
    step("dn0", 1, 0, 0, 0, '0);
    check("dn0.sat", count0, 16'h0000);
    check("dn0.wrap", count1, 16'h1903);
    step("hold", 0, 1, 0, 0, '0);

    step("ld2a05", 0, 0, 0, 1, 16'h2A05);
    check("ld2a05.k", count0, 16'h1903);
    step("ld0a3f", 0, 0, 0, 1, 16'h0A3F);
    check("ld0a3f.k", count0, 16'h0939);

    step("prio", 1, 1, 1, 1, 16'h0555);
    check("prio.k", count1, 16'h0000);

    step("ld457", 0, 0, 0, 1, 16'h0457);
    #2;
    reset = 1'b1;
    #1;
    m[0] = 0; m[1] = 0;
    w[0] = 0; w[1] = 0;
    check_all("arst");
    #1;
    reset = 1'b0;
    step("postrst", 1, 1, 0, 0, '0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      clr = (r < 3);
      ld = (r >= 3 && r < 12);
      en = ($urandom_range(0, 9) != 0);
      ud = ($urandom_range(0, 1) != 0);
      lv = 16'($urandom);
      if (ld && $urandom_range(0, 1) != 0)
        lv = 16'h1890 + 16'($urandom_range(0, 15));
      if (ld && $urandom_range(0, 3) == 0)
        lv = 16'($urandom_range(0, 3));
      step("rnd", en, ud, clr, ld, lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
